// File: rtl/bcd_calc_pkg_v.sv
// Shared types and constants for the BCD calculator engine.
package bcd_calc_pkg_v;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [3:0] BCD_NINE = 4'd9;

  // Nine's complement of one BCD digit.
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_NINE - d;
  endfunction

endpackage

// File: rtl/bcd_digit_adder_v.sv
// Single BCD digit adder: binary sum followed by +6 decimal correction.
module bcd_digit_adder_v (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] bin;

  // Binary add, then correct into the 0..9 range when the sum exceeds nine.
  always_comb begin
    bin = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (bin > 5'd9) begin
      s    = bin[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      s    = bin[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_calc_engine_v.sv
// Signed-magnitude BCD calculator core: keypad edge detection, operand entry,
// digit-serial add/subtract through one shared BCD digit adder.
module bcd_calc_engine_v
  import bcd_calc_pkg_v::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [9:0]           KEY,
  input  logic                 ADD,
  input  logic                 SUB,
  input  logic                 EQUAL,
  input  logic                 CLEAR,
  output logic [4*NDIGITS-1:0] DISP,
  output logic                 NEG,
  output logic                 OVF,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(NDIGITS + 1);
  localparam int IDX_W = $clog2(NDIGITS);

  state_t state_q, state_nxt;

  logic [9:0] key_q;
  logic       add_q, sub_q, eq_q;
  logic       add_ev, sub_ev, eq_ev, op_ev, op_new, dig_ev;
  logic [3:0] dig;

  logic [NDIGITS-1:0][3:0] a_q, b_q, r_q, r_full;
  logic                    sign_a_q, op_q, res_sign_q, carry_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    eff_sub, idx_last, cnt_ok, busy;

  logic [3:0] ad_a, ad_b, ad_s;
  logic       ad_cin, ad_cout;

  // Key history; all ones after reset so a key held through reset is not a press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_q <= '1;
      add_q <= 1'b1;
      sub_q <= 1'b1;
      eq_q  <= 1'b1;
    end else begin
      key_q <= KEY;
      add_q <= ADD;
      sub_q <= SUB;
      eq_q  <= EQUAL;
    end
  end

  // Press events, at most one per cycle: EQUAL over ADD/SUB over digit.
  always_comb begin
    dig = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (KEY[i]) dig = 4'(i);
    end
    add_ev = ADD & ~add_q;
    sub_ev = SUB & ~sub_q;
    eq_ev  = EQUAL & ~eq_q;
    op_ev  = (add_ev ^ sub_ev) & ~eq_ev;
    op_new = sub_ev ? OP_SUB : OP_ADD;
    dig_ev = $onehot(KEY) && (key_q == 10'd0) && !eq_ev && !(add_ev ^ sub_ev);
  end

  assign eff_sub  = sign_a_q ^ (op_q == OP_SUB);
  assign idx_last = (idx_q == IDX_W'(NDIGITS - 1));
  assign cnt_ok   = (cnt_q < CNT_W'(NDIGITS));
  assign busy     = (state_q == S_CALC) || (state_q == S_FIX);

  // Adder operand select: magnitude add/subtract in CALC, ten's complement in FIX.
  always_comb begin
    if (state_q == S_FIX) begin
      ad_a   = nines_comp(r_q[idx_q]);
      ad_b   = 4'd0;
      ad_cin = (idx_q == '0) ? 1'b1 : carry_q;
    end else begin
      ad_a   = a_q[idx_q];
      ad_b   = eff_sub ? nines_comp(b_q[idx_q]) : b_q[idx_q];
      ad_cin = (idx_q == '0) ? eff_sub : carry_q;
    end
    r_full        = r_q;
    r_full[idx_q] = ad_s;
  end

  bcd_digit_adder_v u_adder (
    .a    (ad_a),
    .b    (ad_b),
    .cin  (ad_cin),
    .s    (ad_s),
    .cout (ad_cout)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST || CLEAR) state_q <= S_A;
    else              state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_A:    if (op_ev) state_nxt = S_B;
      S_B:    if (eq_ev) state_nxt = S_CALC;
      S_CALC: if (idx_last) begin
                if (!eff_sub) state_nxt = ad_cout ? S_ERR : S_RES;
                else          state_nxt = ad_cout ? S_RES : S_FIX;
              end
      S_FIX:  if (idx_last) state_nxt = S_RES;
      S_RES:  begin
                if (eq_ev)       state_nxt = S_CALC;
                else if (op_ev)  state_nxt = S_B;
                else if (dig_ev) state_nxt = S_A;
              end
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_A;
    endcase
  end

  // Operand, sign, op and counter registers.
  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        S_A: begin
          if (op_ev) begin
            op_q  <= op_new;
            b_q   <= '0;
            cnt_q <= '0;
          end else if (dig_ev && cnt_ok) begin
            a_q   <= {a_q[NDIGITS-2:0], dig};
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_B: begin
          if (eq_ev) begin
            idx_q <= '0;
          end else if (op_ev) begin
            op_q <= op_new;
          end else if (dig_ev && cnt_ok) begin
            b_q   <= {b_q[NDIGITS-2:0], dig};
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CALC: begin
          idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
          if (idx_last) begin
            if (eff_sub && !ad_cout) begin
              res_sign_q <= ~sign_a_q;
            end else begin
              a_q <= r_full;
              if (r_full == '0) sign_a_q <= 1'b0;
            end
          end
        end
        S_FIX: begin
          idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
          if (idx_last) begin
            a_q      <= r_full;
            sign_a_q <= (r_full == '0) ? 1'b0 : res_sign_q;
          end
        end
        S_RES: begin
          if (eq_ev) begin
            idx_q <= '0;
          end else if (op_ev) begin
            op_q  <= op_new;
            b_q   <= '0;
            cnt_q <= '0;
          end else if (dig_ev) begin
            a_q      <= (4*NDIGITS)'(dig);
            sign_a_q <= 1'b0;
            cnt_q    <= CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Partial result digits and inter-digit carry while a pass is running.
  always_ff @(posedge CLK) begin
    if (busy) begin
      r_q     <= r_full;
      carry_q <= ad_cout;
    end
  end

  // Display and status outputs.
  always_comb begin
    DISP = (state_q == S_B) ? b_q : a_q;
    NEG  = (state_q == S_B) ? 1'b0 : sign_a_q;
    OVF  = (state_q == S_ERR);
    BUSY = busy;
  end

endmodule

// File: tb/tb_bcd_calc_engine_v.sv
// Bench for bcd_calc_engine_v: directed scenarios plus randomized key sequences
// checked against a decimal-arithmetic calculator model.
module tb_bcd_calc_engine_v;

  localparam int N = 4;
  localparam int P = 10000;
  localparam int M_A = 0, M_B = 1, M_RES = 2, M_ERR = 3;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [9:0]     KEY = '0;
  logic           ADD = 1'b0, SUB = 1'b0, EQUAL = 1'b0, CLEAR = 1'b0;
  logic [4*N-1:0] DISP;
  logic           NEG, OVF, BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  int m_a, m_b, m_neg, m_op, m_mode, m_cnt;

  bcd_calc_engine_v #(.NDIGITS(N)) dut (
    .CLK(CLK), .RST(RST), .KEY(KEY), .ADD(ADD), .SUB(SUB), .EQUAL(EQUAL),
    .CLEAR(CLEAR), .DISP(DISP), .NEG(NEG), .OVF(OVF), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press_digit(input int d);
    KEY = 10'(1 << d);
    tick();
    KEY = '0;
    tick();
  endtask

  task automatic press_op(input bit is_sub);
    if (is_sub) SUB = 1'b1;
    else        ADD = 1'b1;
    tick();
    ADD = 1'b0;
    SUB = 1'b0;
    tick();
  endtask

  task automatic press_eq(output int nb);
    EQUAL = 1'b1;
    tick();
    EQUAL = 1'b0;
    nb = 0;
    while (BUSY && nb < 3*N) begin
      nb++;
      tick();
    end
  endtask

  task automatic pulse_clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    tick();
  endtask

  // Model of the calculator in terms of decimal values.
  task automatic model_clear();
    m_a = 0; m_b = 0; m_neg = 0; m_op = 0; m_mode = M_A; m_cnt = 0;
  endtask

  task automatic model_digit(input int d);
    if (m_mode == M_A) begin
      if (m_cnt < N) begin m_a = m_a * 10 + d; m_cnt++; end
    end else if (m_mode == M_B) begin
      if (m_cnt < N) begin m_b = m_b * 10 + d; m_cnt++; end
    end else if (m_mode == M_RES) begin
      m_a = d; m_neg = 0; m_cnt = 1; m_mode = M_A;
    end
  endtask

  task automatic model_op(input bit is_sub);
    if (m_mode == M_A || m_mode == M_RES) begin
      m_op = is_sub; m_b = 0; m_cnt = 0; m_mode = M_B;
    end else if (m_mode == M_B) begin
      m_op = is_sub;
    end
  endtask

  task automatic model_eq(output int exp_busy);
    int av, bv, r, mag;
    bit same;
    exp_busy = 0;
    if (m_mode == M_B || m_mode == M_RES) begin
      av   = (m_neg != 0) ? -m_a : m_a;
      bv   = (m_op != 0) ? -m_b : m_b;
      r    = av + bv;
      mag  = (r < 0) ? -r : r;
      same = ((m_neg != 0) == (m_op != 0));
      exp_busy = (same || m_a >= m_b) ? N : 2*N;
      if (mag >= P) begin
        m_a = mag % P; m_neg = (m_a != 0 && r < 0); m_mode = M_ERR;
      end else begin
        m_a = mag; m_neg = (r < 0); m_mode = M_RES;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    n_tests++; if (DISP !== '0)  begin n_fail++; $display("FAIL reset_disp: got %h expected 0", DISP); end
    n_tests++; if (NEG  !== 1'b0) begin n_fail++; $display("FAIL reset_neg: got %b expected 0", NEG); end
    n_tests++; if (OVF  !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", OVF); end
    n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int nb;
    pulse_clear();
    press_digit(1); press_digit(2); press_op(1'b0); press_digit(7);
    press_eq(nb);
    n_tests++; if (nb != N) begin n_fail++; $display("FAIL add_busy: got %0d expected %0d", nb, N); end
    n_tests++; if (DISP !== 16'h0019) begin n_fail++; $display("FAIL add_disp: got %h expected 0019", DISP); end
    n_tests++; if (NEG !== 1'b0) begin n_fail++; $display("FAIL add_neg: got %b expected 0", NEG); end
    n_tests++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b expected 0", OVF); end
  endtask

  task automatic test_sub_fix();
    int nb;
    pulse_clear();
    press_digit(3); press_op(1'b1); press_digit(8);
    press_eq(nb);
    n_tests++; if (nb != 2*N) begin n_fail++; $display("FAIL fix_busy: got %0d expected %0d", nb, 2*N); end
    n_tests++; if (DISP !== 16'h0005) begin n_fail++; $display("FAIL fix_disp: got %h expected 0005", DISP); end
    n_tests++; if (NEG !== 1'b1) begin n_fail++; $display("FAIL fix_neg: got %b expected 1", NEG); end
  endtask

  task automatic test_overflow();
    int nb;
    pulse_clear();
    for (int i = 0; i < 4; i++) press_digit(9);
    press_op(1'b0); press_digit(1);
    press_eq(nb);
    n_tests++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", OVF); end
    n_tests++; if (DISP !== 16'h0000) begin n_fail++; $display("FAIL ovf_disp: got %h expected 0000", DISP); end
    press_digit(5);
    n_tests++; if (DISP !== 16'h0000 || OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_ignore: got %h/%b expected 0000/1", DISP, OVF); end
    pulse_clear();
    n_tests++; if (OVF !== 1'b0 || DISP !== '0 || NEG !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b/%h/%b expected 0/0000/0", OVF, DISP, NEG); end
  endtask

  task automatic test_entry();
    pulse_clear();
    for (int d = 1; d <= 5; d++) press_digit(d);
    n_tests++; if (DISP !== 16'h1234) begin n_fail++; $display("FAIL entry_limit: got %h expected 1234", DISP); end
    pulse_clear();
    KEY = 10'h080;
    tick(); tick(); tick();
    KEY = '0;
    tick();
    n_tests++; if (DISP !== 16'h0007) begin n_fail++; $display("FAIL entry_held: got %h expected 0007", DISP); end
    KEY = 10'h003;
    tick();
    KEY = '0;
    tick();
    n_tests++; if (DISP !== 16'h0007) begin n_fail++; $display("FAIL entry_multikey: got %h expected 0007", DISP); end
  endtask

  task automatic test_chain();
    int nb;
    pulse_clear();
    press_digit(5); press_op(1'b0); press_digit(3);
    press_eq(nb);
    n_tests++; if (DISP !== 16'h0008) begin n_fail++; $display("FAIL chain_first: got %h expected 0008", DISP); end
    press_eq(nb);
    n_tests++; if (DISP !== 16'h0011 || nb != N) begin n_fail++; $display("FAIL chain_repeat: got %h/%0d expected 0011/%0d", DISP, nb, N); end
    press_op(1'b1); press_digit(2); press_digit(0);
    n_tests++; if (DISP !== 16'h0020 || NEG !== 1'b0) begin n_fail++; $display("FAIL chain_bshow: got %h/%b expected 0020/0", DISP, NEG); end
    press_eq(nb);
    n_tests++; if (DISP !== 16'h0009 || NEG !== 1'b1 || nb != 2*N) begin n_fail++; $display("FAIL chain_sub: got %h/%b/%0d expected 0009/1/%0d", DISP, NEG, nb, 2*N); end
  endtask

  task automatic test_rst_abort();
    pulse_clear();
    press_digit(1); press_op(1'b0); press_digit(2);
    EQUAL = 1'b1;
    tick();
    EQUAL = 1'b0;
    tick();
    n_tests++; if (BUSY !== 1'b1 || DISP !== 16'h0001) begin n_fail++; $display("FAIL abort_busy: got %b/%h expected 1/0001", BUSY, DISP); end
    RST = 1'b1;
    KEY = 10'h010;
    tick();
    n_tests++; if (DISP !== '0 || NEG !== 1'b0 || OVF !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: got %h/%b/%b/%b expected 0/0/0/0", DISP, NEG, OVF, BUSY); end
    RST = 1'b0;
    tick(); tick();
    n_tests++; if (DISP !== '0) begin n_fail++; $display("FAIL abort_held: got %h expected 0000", DISP); end
    KEY = '0;
    tick();
    press_digit(4);
    n_tests++; if (DISP !== 16'h0004) begin n_fail++; $display("FAIL abort_repress: got %h expected 0004", DISP); end
  endtask

  task automatic test_random();
    int nb, eb, sel, d;
    logic [4*N-1:0] ed;
    bit is_sub;
    pulse_clear();
    model_clear();
    for (int it = 0; it < 300; it++) begin
      sel = $urandom_range(0, 99);
      if (m_mode == M_ERR && sel < 50) sel = 99;
      eb = 0;
      nb = 0;
      if (sel < 50) begin
        d = $urandom_range(0, 9);
        press_digit(d);
        model_digit(d);
      end else if (sel < 70) begin
        is_sub = 1'($urandom_range(0, 1));
        press_op(is_sub);
        model_op(is_sub);
      end else if (sel < 95) begin
        press_eq(nb);
        model_eq(eb);
        n_tests++; if (nb != eb) begin n_fail++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", it, nb, eb); end
      end else begin
        pulse_clear();
        model_clear();
      end
      ed = (m_mode == M_B) ? to_bcd(m_b) : to_bcd(m_a);
      n_tests++; if (DISP !== ed) begin n_fail++; $display("FAIL rand_disp[%0d]: got %h expected %h", it, DISP, ed); end
      n_tests++; if (NEG !== ((m_mode != M_B) && (m_neg != 0))) begin n_fail++; $display("FAIL rand_neg[%0d]: got %b expected %0d", it, NEG, (m_mode != M_B) && (m_neg != 0)); end
      n_tests++; if (OVF !== (m_mode == M_ERR)) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b expected %0d", it, OVF, m_mode == M_ERR); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_fix();
    test_overflow();
    test_entry();
    test_chain();
    test_rst_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
